// File: rtl/servo_slew.sv
// Per-channel slew-rate limiter feeding the RC servo PWM stage: a bus-mapped target and rate per
// channel, and a periodic scan that steps each current position toward its target.
module servo_slew #(
  parameter int unsigned NUM_SERVO = 2,
  parameter int unsigned TICK_DIV  = 20000
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [4:0]             Addr,
  input  logic [15:0]            DataWr,
  output logic [15:0]            DataRd,
  input  logic                   En,
  input  logic                   Rd,
  input  logic                   Wr,
  output logic [NUM_SERVO*8-1:0] Pos
);

  localparam int unsigned KW  = (NUM_SERVO > 1) ? $clog2(NUM_SERVO) : 1;
  localparam int unsigned TCW = $clog2(TICK_DIV);
  localparam logic [4:0]  ADDR_STATUS = 5'h1E;
  localparam logic [4:0]  ADDR_CTRL   = 5'h1F;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, stateNext;
  logic [KW-1:0]    k, kNext;
  logic [TCW-1:0]   tickCnt;
  logic             enable, overrun;
  logic [7:0]       tgt  [NUM_SERVO];
  logic [7:0]       rate [NUM_SERVO];
  logic [7:0]       cur  [NUM_SERVO];

  logic             tick, scanEn, wrEn, snap, statusWr, ctrlWr;
  logic [7:0]       curK, tgtK, rateK, stepVal;
  logic signed [8:0] d;
  logic [8:0]       mag;
  logic             unusedRd;

  // Reads have no side effects, so the strobe is not needed.
  assign unusedRd = Rd;

  assign wrEn     = Wr & En;
  assign ctrlWr   = wrEn && (Addr == ADDR_CTRL);
  assign statusWr = wrEn && (Addr == ADDR_STATUS);
  assign snap     = ctrlWr && DataWr[1];
  assign tick     = enable && (tickCnt == TCW'(TICK_DIV - 1));

  always_comb begin
    stateNext = state;
    kNext     = k;
    scanEn    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          stateNext = SCAN;
          kNext     = '0;
        end
      end
      SCAN: begin
        scanEn = 1'b1;
        if (k == KW'(NUM_SERVO - 1)) begin
          stateNext = IDLE;
          kNext     = '0;
        end else begin
          kNext = k + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (snap) begin
      stateNext = IDLE;
      kNext     = '0;
    end
  end

  always_comb begin
    curK  = '0;
    tgtK  = '0;
    rateK = '0;
    for (int unsigned i = 0; i < NUM_SERVO; i++) begin
      if (k == KW'(i)) begin
        curK  = cur[i];
        tgtK  = tgt[i];
        rateK = rate[i];
      end
    end
  end

  // Step computed on the pre-edge register values, so a same-cycle write only affects later scans.
  always_comb begin
    d   = $signed({1'b0, tgtK}) - $signed({1'b0, curK});
    mag = d[8] ? 9'(-d) : 9'(d);
    if ((rateK == 8'h00) || (mag <= {1'b0, rateK})) begin
      stepVal = tgtK;
    end else if (!d[8]) begin
      stepVal = curK + rateK;
    end else begin
      stepVal = curK - rateK;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      k       <= '0;
      tickCnt <= '0;
      enable  <= 1'b0;
      overrun <= 1'b0;
      for (int unsigned i = 0; i < NUM_SERVO; i++) begin
        tgt[i]  <= 8'h80;
        rate[i] <= 8'h00;
        cur[i]  <= 8'h80;
      end
    end else begin
      state   <= stateNext;
      k       <= kNext;
      tickCnt <= (tickCnt == TCW'(TICK_DIV - 1)) ? '0 : tickCnt + 1'b1;
      if (ctrlWr) begin
        enable <= DataWr[0];
      end
      if (statusWr) begin
        overrun <= 1'b0;
      end
      if (tick && (state == SCAN)) begin
        overrun <= 1'b1;
      end
      for (int unsigned i = 0; i < NUM_SERVO; i++) begin
        if (wrEn && (Addr == 5'(i))) begin
          tgt[i]  <= DataWr[7:0];
          rate[i] <= DataWr[15:8];
        end
        if (snap) begin
          cur[i] <= tgt[i];
        end else if (scanEn && (k == KW'(i))) begin
          cur[i] <= stepVal;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SERVO; i++) begin
      Pos[i*8 +: 8] = cur[i];
    end
  end

  always_comb begin
    DataRd = '0;
    for (int unsigned i = 0; i < NUM_SERVO; i++) begin
      if (Addr == 5'(i)) begin
        DataRd = {rate[i], tgt[i]};
      end
    end
    if (Addr == ADDR_STATUS) begin
      for (int unsigned i = 0; i < NUM_SERVO; i++) begin
        if (i < 15) begin
          DataRd[i] = (cur[i] != tgt[i]);
        end
      end
      DataRd[15] = overrun;
    end
    if (Addr == ADDR_CTRL) begin
      DataRd[0] = enable;
    end
  end

endmodule

// File: tb/tb_servo_slew.sv
// Directed bench for servo_slew: slew, clamp, rate-0 jump, snap, overrun and same-cycle writes.
module tb_servo_slew;

  localparam int unsigned NS = 2;
  localparam int unsigned TD = NS + 2;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [4:0]    Addr;
  logic [15:0]   DataWr;
  logic [15:0]   DataRd;
  logic          En, Rd, Wr;
  logic [NS*8-1:0] Pos;

  int checks = 0;
  int errors = 0;
  int tbCnt  = 0;
  logic tbEn = 1'b0;
  logic lastTick = 1'b0;

  always #5 Clk = ~Clk;

  servo_slew #(.NUM_SERVO(NS), .TICK_DIV(TD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
    .En(En), .Rd(Rd), .Wr(Wr), .Pos(Pos)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; tracks the tick counter and enable to know whether this edge was a tick.
  task automatic step();
    @(posedge Clk);
    #1;
    lastTick = (tbCnt == TD - 1) && tbEn;
    tbCnt = (tbCnt + 1) % TD;
  endtask

  task automatic busWrite(input logic [4:0] a, input logic [15:0] dat);
    Addr = a; DataWr = dat; En = 1'b1; Wr = 1'b1;
    step();
    En = 1'b0; Wr = 1'b0;
    if (a == 5'h1F) tbEn = dat[0];
  endtask

  task automatic busRead(input logic [4:0] a, output logic [15:0] dat);
    Addr = a; En = 1'b1; Rd = 1'b1;
    #1;
    dat = DataRd;
    En = 1'b0; Rd = 1'b0;
  endtask

  task automatic nextTick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!lastTick && n < 4 * TD);
    check("tickSeen", {15'b0, lastTick}, 16'd1);
  endtask

  logic [15:0] rv;
  logic [7:0]  slewExp [4] = '{8'h85, 8'h8A, 8'h8F, 8'h90};
  logic [7:0]  downExp [4] = '{8'h50, 8'h20, 8'h00, 8'h00};

  initial begin
    Rst_n = 1'b0; Addr = '0; DataWr = '0; En = 1'b0; Rd = 1'b0; Wr = 1'b0;
    repeat (2) step();
    Rst_n = 1'b1;
    tbCnt = 0; tbEn = 1'b0;
    check("rstPos", Pos, 16'h8080);
    busRead(5'h1F, rv); check("rstCtrl", rv, 16'h0000);
    busRead(5'h1E, rv); check("rstStatus", rv, 16'h0000);

    // Slew up by 5 toward 0x90
    busWrite(5'h00, 16'h0590);
    busWrite(5'h1F, 16'h0001);
    busRead(5'h1E, rv); check("slewMoving", rv, 16'h0001);
    for (int j = 0; j < 4; j++) begin
      nextTick();
      step();
      check($sformatf("slew%0d", j), {8'h00, Pos[7:0]}, {8'h00, slewExp[j]});
      step();
      busRead(5'h1E, rv);
      check($sformatf("slewStatus%0d", j), rv, (j == 3) ? 16'h0000 : 16'h0001);
    end

    // Down with clamp at zero
    busWrite(5'h1F, 16'h0000);
    repeat (3) step();
    busWrite(5'h00, 16'h0080);
    busWrite(5'h1F, 16'h0002);
    check("snapTo80", Pos, 16'h8080);
    busWrite(5'h00, 16'h3000);
    busWrite(5'h1F, 16'h0001);
    for (int j = 0; j < 4; j++) begin
      nextTick();
      step();
      check($sformatf("down%0d", j), {8'h00, Pos[7:0]}, {8'h00, downExp[j]});
    end

    // Rate 0 jumps at Tick+1
    busWrite(5'h00, 16'h00FF);
    nextTick();
    step();
    check("rate0Jump", {8'h00, Pos[7:0]}, 16'h00FF);

    // Snap with Enable kept
    busWrite(5'h00, 16'h0110);
    busWrite(5'h1F, 16'h0003);
    check("snapCur0", {8'h00, Pos[7:0]}, 16'h0010);
    busRead(5'h1E, rv); check("snapStatus", rv, 16'h0000);
    busRead(5'h1F, rv); check("snapCtrl", rv, 16'h0001);

    // Overrun: preset the divider so a tick lands while scanning
    nextTick();
    dut.tickCnt = 2'd3;
    tbCnt = TD - 1;
    step();
    step();
    busRead(5'h1E, rv); check("overrunSet", rv, 16'h8000);
    busWrite(5'h1E, 16'h0000);
    busRead(5'h1E, rv); check("overrunClr", rv, 16'h0000);

    // Same-cycle write on channel 1
    busWrite(5'h1F, 16'h0000);
    repeat (3) step();
    busWrite(5'h1F, 16'h0002);
    busWrite(5'h01, 16'h10C0);
    busWrite(5'h1F, 16'h0001);
    nextTick();
    step();
    check("ch1NotYet", {8'h00, Pos[15:8]}, 16'h0080);
    busWrite(5'h01, 16'h1020);
    check("ch1OldTgt", {8'h00, Pos[15:8]}, 16'h0090);
    nextTick();
    step();
    step();
    check("ch1NewTgt", {8'h00, Pos[15:8]}, 16'h0080);
    nextTick();
    busWrite(5'h01, 16'h1090);
    step();
    check("ch1EarlyWr", {8'h00, Pos[15:8]}, 16'h0090);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
